tnoc_vc_credit_manager: RTL and testbench



---
 rtl/tnoc_vc_credit_manager.sv | 96 +++++++++
 tb/tb_tnoc_vc_credit_manager.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tnoc_vc_credit_manager.sv
// Per-VC credit counters for one NoC output port: saturating counters, registered
// VC-availability vector and sticky, set-dominant protocol error flags.
module tnoc_vc_credit_manager #(
    parameter int CHANNELS = 2,
    parameter int CREDITS  = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [CHANNELS-1:0]                            i_flit_sent,
    input  logic [CHANNELS-1:0]                            i_credit_return,
    input  logic                                           i_clear_error,
    output logic [CHANNELS-1:0]                            o_vc_available,
    output logic [CHANNELS*$clog2(CREDITS+1)-1:0]          o_credit_count,
    output logic [CHANNELS-1:0]                            o_overflow,
    output logic [CHANNELS-1:0]                            o_underflow
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CREDITS);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CHANNELS-1:0][CW-1:0] cnt_q;
    logic [CHANNELS-1:0][CW-1:0] cnt_d;
    logic [CHANNELS-1:0]         avail_q;
    logic [CHANNELS-1:0]         avail_d;
    logic [CHANNELS-1:0]         overflow_q;
    logic [CHANNELS-1:0]         overflow_d;
    logic [CHANNELS-1:0]         underflow_q;
    logic [CHANNELS-1:0]         underflow_d;
    logic [CHANNELS-1:0]         ovf_event_s;
    logic [CHANNELS-1:0]         unf_event_s;

    // Next-state counters: send and return in the same cycle cancel, never wrap.
    always_comb begin
        cnt_d       = cnt_q;
        ovf_event_s = {CHANNELS{1'b0}};
        unf_event_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            case ({i_flit_sent[i], i_credit_return[i]})
                2'b10: begin
                    if (cnt_q[i] == CNT_ZERO) begin
                        unf_event_s[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                2'b01: begin
                    if (cnt_q[i] == CNT_FULL) begin
                        ovf_event_s[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d[i] = cnt_q[i];
                end
            endcase
        end
    end

    // Availability is derived from the next count so it always matches the counter.
    always_comb begin
        avail_d = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            avail_d[i] = (cnt_d[i] != CNT_ZERO);
        end
    end

    // Sticky errors; a new event in the same cycle wins over the clear.
    always_comb begin
        overflow_d  = ovf_event_s | (overflow_q  & ~{CHANNELS{i_clear_error}});
        underflow_d = unf_event_s | (underflow_q & ~{CHANNELS{i_clear_error}});
    end

    // State registers; reset restores full credits and discards same-cycle events.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= {CHANNELS{CNT_FULL}};
            avail_q     <= {CHANNELS{1'b1}};
            overflow_q  <= {CHANNELS{1'b0}};
            underflow_q <= {CHANNELS{1'b0}};
        end else begin
            cnt_q       <= cnt_d;
            avail_q     <= avail_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_credit_count = cnt_q;
    assign o_vc_available = avail_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_tnoc_vc_credit_manager.sv
// Directed bench for tnoc_vc_credit_manager (CHANNELS=2, CREDITS=8, 4-bit counters).
module tb_tnoc_vc_credit_manager;

    logic       clk;
    logic       rst;
    logic [1:0] i_flit_sent;
    logic [1:0] i_credit_return;
    logic       i_clear_error;
    logic [1:0] o_vc_available;
    logic [7:0] o_credit_count;
    logic [1:0] o_overflow;
    logic [1:0] o_underflow;

    int n_checks;
    int n_pass;

    tnoc_vc_credit_manager #(.CHANNELS(2), .CREDITS(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_flit_sent     (i_flit_sent),
        .i_credit_return (i_credit_return),
        .i_clear_error   (i_clear_error),
        .o_vc_available  (o_vc_available),
        .o_credit_count  (o_credit_count),
        .o_overflow      (o_overflow),
        .o_underflow     (o_underflow)
    );

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one rising edge, then settle 1 time unit past it.
    task automatic cycle(input logic [1:0] s, input logic [1:0] r, input logic clr);
        i_flit_sent     = s;
        i_credit_return = r;
        i_clear_error   = clr;
        @(posedge clk);
        #1;
        i_flit_sent     = 2'b00;
        i_credit_return = 2'b00;
        i_clear_error   = 1'b0;
    endtask

    int unsigned m_cnt;
    logic        m_unf;
    logic        m_ovf;
    logic        rs;
    logic        rr;

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst             = 1'b1;
        i_flit_sent     = 2'b00;
        i_credit_return = 2'b00;
        i_clear_error   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state after idle
        for (int k = 0; k < 5; k++) cycle(2'b00, 2'b00, 1'b0);
        check_eq("rst_count", 32'(o_credit_count), 32'h88);
        check_eq("rst_avail", 32'(o_vc_available), 32'h3);
        check_eq("rst_ovf",   32'(o_overflow),     32'h0);
        check_eq("rst_unf",   32'(o_underflow),    32'h0);

        // Drain VC0: 7..0, availability drops after the 8th send
        for (int k = 1; k <= 8; k++) begin
            cycle(2'b01, 2'b00, 1'b0);
            check_eq("drain_cnt0",   32'(o_credit_count[3:0]), 32'(8 - k));
            check_eq("drain_avail0", 32'(o_vc_available[0]),   (k < 8) ? 32'd1 : 32'd0);
        end
        check_eq("drain_cnt1",   32'(o_credit_count[7:4]), 32'd8);
        check_eq("drain_avail1", 32'(o_vc_available[1]),   32'd1);

        // Underflow at zero, sticky, then cleared
        cycle(2'b01, 2'b00, 1'b0);
        check_eq("unf_cnt0", 32'(o_credit_count[3:0]), 32'd0);
        check_eq("unf_set",  32'(o_underflow),         32'h1);
        cycle(2'b00, 2'b00, 1'b0);
        check_eq("unf_sticky", 32'(o_underflow), 32'h1);
        cycle(2'b00, 2'b00, 1'b1);
        check_eq("unf_clear", 32'(o_underflow), 32'h0);

        // Overflow on VC1 at full, then set-dominant over clear
        cycle(2'b00, 2'b10, 1'b0);
        check_eq("ovf_cnt1", 32'(o_credit_count[7:4]), 32'd8);
        check_eq("ovf_set",  32'(o_overflow),          32'h2);
        cycle(2'b00, 2'b00, 1'b1);
        check_eq("ovf_clear", 32'(o_overflow), 32'h0);
        cycle(2'b00, 2'b10, 1'b1);
        check_eq("ovf_setdom", 32'(o_overflow), 32'h2);
        cycle(2'b00, 2'b00, 1'b1);

        // Send+return together: VC0 at 0, VC1 at 8 -> hold, no errors
        cycle(2'b11, 2'b11, 1'b0);
        check_eq("both_count", 32'(o_credit_count), 32'h80);
        check_eq("both_avail", 32'(o_vc_available), 32'h2);
        check_eq("both_errs",  32'({o_overflow, o_underflow}), 32'h0);

        // Last credit returns: availability back one cycle later
        cycle(2'b00, 2'b01, 1'b0);
        check_eq("ret_avail0", 32'(o_vc_available[0]), 32'd1);
        cycle(2'b00, 2'b01, 1'b0);
        cycle(2'b00, 2'b01, 1'b0);
        check_eq("ret_cnt0_3", 32'(o_credit_count[3:0]), 32'd3);

        // Random send/return on VC0 against a saturating scoreboard
        m_cnt = 3;
        m_unf = 1'b0;
        m_ovf = 1'b0;
        for (int k = 0; k < 20; k++) begin
            rs = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            cycle({1'b0, rs}, {1'b0, rr}, 1'b0);
            if (rs && !rr) begin
                if (m_cnt == 0) m_unf = 1'b1;
                else            m_cnt = m_cnt - 1;
            end else if (rr && !rs) begin
                if (m_cnt == 8) m_ovf = 1'b1;
                else            m_cnt = m_cnt + 1;
            end
            check_eq("rnd_cnt0",   32'(o_credit_count[3:0]), m_cnt);
            check_eq("rnd_avail0", 32'(o_vc_available[0]),   (m_cnt != 0) ? 32'd1 : 32'd0);
            check_eq("rnd_le8",    32'(o_credit_count[3:0] <= 4'd8), 32'd1);
            check_eq("rnd_unf0",   32'(o_underflow[0]), 32'(m_unf));
            check_eq("rnd_ovf0",   32'(o_overflow[0]),  32'(m_ovf));
        end

        // Refill VC0 to 8, then send+return at full holds with no error
        cycle(2'b00, 2'b00, 1'b1);
        for (int k = 0; k < 8; k++) cycle(2'b00, 2'b01, 1'b0);
        cycle(2'b00, 2'b00, 1'b1);
        check_eq("full_cnt0", 32'(o_credit_count[3:0]), 32'd8);
        cycle(2'b01, 2'b01, 1'b0);
        check_eq("full_both_cnt0", 32'(o_credit_count[3:0]), 32'd8);
        check_eq("full_both_errs", 32'({o_overflow, o_underflow}), 32'h0);

        // Mid-traffic reset with sends present
        for (int k = 0; k < 3; k++) cycle(2'b01, 2'b00, 1'b0);
        check_eq("pre_cnt0", 32'(o_credit_count), 32'h85);
        for (int k = 0; k < 9; k++) cycle(2'b10, 2'b00, 1'b0);
        check_eq("pre_unf1", 32'(o_underflow), 32'h2);
        check_eq("pre_avail", 32'(o_vc_available), 32'h1);
        rst = 1'b1;
        cycle(2'b11, 2'b00, 1'b0);
        rst = 1'b0;
        check_eq("mrst_count", 32'(o_credit_count), 32'h88);
        check_eq("mrst_avail", 32'(o_vc_available), 32'h3);
        check_eq("mrst_errs",  32'({o_overflow, o_underflow}), 32'h0);

        // One-cycle latency after reset release
        cycle(2'b10, 2'b00, 1'b0);
        check_eq("lat_count", 32'(o_credit_count), 32'h78);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
